// File: rtl/core_bus_pkg.sv
// Shared definitions for the core bus initiator: FSM encoding, CPU address field layout, defaults.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
// Build option: CORE_BUS_TIMEOUT_EN (used by core_bus_initiator) enables the ACCESS abort counter.
package core_bus_pkg;

  // Transaction FSM: one outstanding access at a time.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // CPU byte-address layout for core register accesses.
  // Bits [23:10] carry no meaning for the core bus and are ignored.
  localparam int PREFIX_HI = 31;
  localparam int PREFIX_LO = 30;
  localparam int IDX_HI    = 29;
  localparam int IDX_LO    = 24;
  localparam int REG_HI    = 9;
  localparam int REG_LO    = 2;

  localparam int PREFIX_W = PREFIX_HI - PREFIX_LO + 1;
  localparam int IDX_W    = IDX_HI - IDX_LO + 1;
  localparam int REG_W    = REG_HI - REG_LO + 1;

  localparam logic [PREFIX_W-1:0] DEFAULT_MMIO_PREFIX = 2'b11;

  // Read data returned alongside an error response.
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // Only full-word writes reach the cores; partial strobes are rejected.
  function automatic logic strobe_ok(input logic we, input logic [3:0] wstrb);
    return !we || (wstrb == 4'hf);
  endfunction

endpackage

// File: rtl/core_bus_timeout.sv
// Abort counter for the ACCESS phase: flags expiry when the selected core stays silent too long.
// Latency: expired_o is combinational from the count; counts from the first ACCESS cycle.
// Backpressure: none; a ready in the expiry cycle suppresses expired_o so completion wins.
//
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   start_i      : pulse in the cycle the FSM enters ACCESS (clears the count)
//   active_i     : FSM is in ACCESS
//   ready_i      : the selected core answered this cycle
//   expired_o    : ACCESS has lasted TIMEOUT_CYCLES cycles with no answer
module core_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic active_i,
  input  logic ready_i,
  output logic expired_o
);

  // At least 8 bits, wider only when the limit needs it.
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // The count equals the number of completed silent ACCESS cycles, so the
  // TIMEOUT_CYCLES-th silent cycle is the one seeing LAST.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i && !ready_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = active_i && !ready_i && (cnt_q == LAST);

endmodule

// File: rtl/core_bus_initiator.sv
// MMIO initiator: decodes a CPU word request to one core register and runs a single cs/ready access.
// Latency: legal request seen in cycle N -> core_cs in N+1 -> cpu_ready in N+2+waits; illegal -> cpu_ready in N+1.
// Backpressure: cpu side waits for the one-cycle cpu_ready strobe; core side stretches ACCESS until core_ready[idx].
//
// Build option: define CORE_BUS_TIMEOUT_EN to abort an ACCESS after TIMEOUT_CYCLES silent cycles
// (error response). Without it ACCESS waits indefinitely for the selected core.
//
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   cpu_valid/we/addr     : CPU request (valid held until cpu_ready), byte address
//   cpu_wstrb/cpu_wdata   : write strobes (must be 4'hf) and write data
//   cpu_ready             : one-cycle response strobe; cpu_rdata/cpu_error valid with it
//   core_cs               : one-hot core select, held for the whole access
//   core_we/core_address/core_write_data : access attributes, stable while core_cs is high
//   core_read_data        : packed per-core read data, core i at [32*i+31:32*i]
//   core_ready            : per-core ready, combinational with core_cs inside the cores
module core_bus_initiator
  import core_bus_pkg::*;
#(
  parameter int                  NUM_CORES      = 4,
  parameter logic [PREFIX_W-1:0] MMIO_PREFIX    = DEFAULT_MMIO_PREFIX,
  parameter int                  TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cpu_valid,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [3:0]              cpu_wstrb,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_ready,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_error,
  output logic [NUM_CORES-1:0]    core_cs,
  output logic                    core_we,
  output logic [7:0]              core_address,
  output logic [31:0]             core_write_data,
  input  logic [NUM_CORES*32-1:0] core_read_data,
  input  logic [NUM_CORES-1:0]    core_ready
);

  // ---------------------------------------------------------------------------
  // Request decode (combinational, sampled only in IDLE)
  // ---------------------------------------------------------------------------
  logic [PREFIX_W-1:0]  req_prefix;
  logic [IDX_W-1:0]     req_idx;
  logic [REG_W-1:0]     req_reg;
  logic [NUM_CORES-1:0] req_onehot;
  logic                 req_legal;
  logic                 unused_addr_bits;

  assign req_prefix = cpu_addr[PREFIX_HI:PREFIX_LO];
  assign req_idx    = cpu_addr[IDX_HI:IDX_LO];
  assign req_reg    = cpu_addr[REG_HI:REG_LO];

  // Middle address bits are a don't-care window between core index and register.
  assign unused_addr_bits = ^cpu_addr[IDX_LO-1:REG_HI+1];

  // An out-of-range index decodes to all zeros, which doubles as the range check.
  always_comb begin
    req_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req_onehot[i] = (req_idx == IDX_W'(i));
    end
  end

  assign req_legal = (req_prefix == MMIO_PREFIX) &&
                     (|req_onehot) &&
                     (cpu_addr[1:0] == 2'b00) &&
                     strobe_ok(cpu_we, cpu_wstrb);

  // ---------------------------------------------------------------------------
  // Selected-core response: the one-hot select masks ready and steers read data,
  // so a ready from any other core has no effect.
  // ---------------------------------------------------------------------------
  logic [NUM_CORES-1:0] core_cs_q;
  logic                 ready_hit;
  logic [31:0]          sel_rdata;

  assign ready_hit = |(core_ready & core_cs_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_cs_q[i]) begin
        sel_rdata = sel_rdata | core_read_data[32*i +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional ACCESS timeout
  // ---------------------------------------------------------------------------
  bus_state_e state_q;
  logic       access_start;
  logic       in_access;
  logic       timeout_hit;

  assign access_start = (state_q == ST_IDLE) && cpu_valid && req_legal;
  assign in_access    = (state_q == ST_ACCESS);

`ifdef CORE_BUS_TIMEOUT_EN
  core_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (access_start),
    .active_i  (in_access),
    .ready_i   (ready_hit),
    .expired_o (timeout_hit)
  );
`else
  logic [31:0] unused_timeout_cfg;
  logic        unused_timeout_sig;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign unused_timeout_sig = access_start ^ in_access;
  assign timeout_hit        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic        cpu_ready_q;
  logic [31:0] cpu_rdata_q;
  logic        cpu_error_q;
  logic        core_we_q;
  logic [7:0]  core_addr_q;
  logic [31:0] core_wdata_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cpu_ready_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_error_q  <= 1'b0;
      core_cs_q    <= '0;
      core_we_q    <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
    end else begin
      // cpu_ready is only ever raised on the edge that enters RESP.
      cpu_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_valid) begin
            if (req_legal) begin
              core_cs_q    <= req_onehot;
              core_we_q    <= cpu_we;
              core_addr_q  <= req_reg;
              core_wdata_q <= cpu_wdata;
              state_q      <= ST_ACCESS;
            end else begin
              // Rejected without touching the core bus.
              cpu_ready_q <= 1'b1;
              cpu_error_q <= 1'b1;
              cpu_rdata_q <= ERR_RDATA;
              state_q     <= ST_RESP;
            end
          end
        end

        ST_ACCESS: begin
          if (ready_hit || timeout_hit) begin
            cpu_ready_q  <= 1'b1;
            // Ready takes priority; timeout_hit is already gated by ready.
            cpu_error_q  <= !ready_hit;
            cpu_rdata_q  <= (ready_hit && !core_we_q) ? sel_rdata : ERR_RDATA;
            core_cs_q    <= '0;
            core_we_q    <= 1'b0;
            core_addr_q  <= '0;
            core_wdata_q <= '0;
            state_q      <= ST_RESP;
          end
        end

        ST_RESP: begin
          // Clear here so the IDLE cycle that follows already shows zero data.
          cpu_rdata_q <= '0;
          cpu_error_q <= 1'b0;
          state_q     <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready       = cpu_ready_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign cpu_error       = cpu_error_q;
  assign core_cs         = core_cs_q;
  assign core_we         = core_we_q;
  assign core_address    = core_addr_q;
  assign core_write_data = core_wdata_q;

endmodule
